// File: rtl/csi_rx_raw8_pixel_unpacker_if.sv
// Stream bundle for the RAW8 pixel unpacker.
// Carries the packet-handler payload side, the 2-pixel output stream and the status flag.
// slave is the unpacker's view. master is the view of the environment that drives
// the payload and consumes the pixels.
interface csi_rx_raw8_pixel_unpacker_if #(
  parameter int XW = 12,
  parameter int YW = 12
);
  logic [31:0]   payload_data;
  logic          payload_enable;
  logic          payload_frame;
  logic          vsync;
  logic [15:0]   pix_data;
  logic          pix_valid;
  logic          pix_ready;
  logic          pix_sof;
  logic          pix_sol;
  logic          pix_eol;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          overflow;

  modport slave (
    input  payload_data, payload_enable, payload_frame, vsync, pix_ready,
    output pix_data, pix_valid, pix_sof, pix_sol, pix_eol, pix_x, pix_y, overflow
  );

  modport master (
    output payload_data, payload_enable, payload_frame, vsync, pix_ready,
    input  pix_data, pix_valid, pix_sof, pix_sol, pix_eol, pix_x, pix_y, overflow
  );
endinterface

// File: rtl/csi_rx_raw8_pixel_unpacker.sv
// RAW8 pixel unpacker.
// CSI-2 payload words (4 pixels each) are delayed by one word so that the last word
// of a line can be tagged. They are then buffered in a FIFO and emitted as 2-pixel
// beats with SOF/SOL/EOL markers and x/y coordinates.
module csi_rx_raw8_pixel_unpacker #(
  parameter int FIFO_DEPTH = 512,
  parameter int XW         = 12,
  parameter int YW         = 12
) (
  input  logic                         clock,
  input  logic                         reset,
  csi_rx_raw8_pixel_unpacker_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] TWO_C   = (AW+1)'(2);

  typedef struct packed {
    logic        sof;
    logic        sol;
    logic        eol;
    logic [31:0] word;
  } entry_t;

  // ---------------- input framing ----------------
  logic        frame_q;
  logic        hold_vld;
  logic        hold_sol;
  logic        hold_sof;
  logic [31:0] hold_word;
  logic        sol_pending;
  logic        sof_pending;

  logic        load;
  logic        fall;
  logic        new_sol;
  logic        new_sof;
  logic        wr_en;
  entry_t      wr_entry;

  // Decode the payload events.
  // vsync counts as pending when it lands on the same cycle as a load.
  always_comb begin
    load     = bus.payload_enable & bus.payload_frame;
    fall     = frame_q & ~bus.payload_frame;
    new_sol  = sol_pending | bus.vsync;
    new_sof  = (sof_pending | bus.vsync) & new_sol;
    wr_en    = hold_vld & (load | fall);
    wr_entry = {hold_sof, hold_sol, fall, hold_word};
  end

  // Hold register and line/frame pending flags.
  // A dropped FIFO write still advances this state.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_q     <= 1'b0;
      hold_vld    <= 1'b0;
      hold_sol    <= 1'b0;
      hold_sof    <= 1'b0;
      hold_word   <= '0;
      sol_pending <= 1'b1;
      sof_pending <= 1'b0;
    end else begin
      frame_q <= bus.payload_frame;
      if (load) begin
        hold_vld  <= 1'b1;
        hold_word <= bus.payload_data;
        hold_sol  <= new_sol;
        hold_sof  <= new_sof;
      end else if (fall) begin
        hold_vld  <= 1'b0;
      end
      if (load)
        sol_pending <= 1'b0;
      else if (bus.vsync || (fall && hold_vld))
        sol_pending <= 1'b1;
      if (load && new_sof)
        sof_pending <= 1'b0;
      else if (bus.vsync)
        sof_pending <= 1'b1;
    end
  end

  // ---------------- FIFO ----------------
  entry_t        mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   count;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] rd_idx_nxt;
  logic          full;
  logic          pop;
  logic          wr_acc;
  entry_t        head;
  entry_t        nxt;
  logic          nxt_avail;
  logic          overflow_q;

  // Occupancy and read views.
  // nxt is the entry behind the head. When the head is the only entry, nxt
  // bypasses from the write port so back-to-back words do not bubble.
  always_comb begin
    count      = wr_ptr - rd_ptr;
    full       = (count == DEPTH_C);
    rd_idx     = rd_ptr[AW-1:0];
    rd_idx_nxt = rd_idx + AW'(1);
    wr_acc     = wr_en & (~full | pop);
    head       = mem[rd_idx];
    nxt        = (count >= TWO_C) ? mem[rd_idx_nxt] : wr_entry;
    nxt_avail  = (count >= TWO_C) | wr_en;
  end

  // Storage array. It needs no reset because the pointers define which entries are live.
  always_ff @(posedge clock) begin
    if (wr_acc)
      mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  // Pointers and the sticky drop flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)
        rd_ptr <= rd_ptr + (AW+1)'(1);
      if (wr_en && !wr_acc)
        overflow_q <= 1'b1;
    end
  end

  // ---------------- output beat register ----------------
  logic [15:0]   data_q;
  logic          valid_q;
  logic          phase_q;
  logic          sof_q;
  logic          sol_q;
  logic          eol_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  logic          hs;
  logic          ld;
  logic          ld_phase;
  entry_t        ld_entry;
  logic [15:0]   ld_data;
  logic          ld_sof;
  logic          ld_sol;
  logic          ld_eol;
  logic [XW-1:0] ld_x;
  logic [YW-1:0] ld_y;

  // Pick the next beat. The register is only refilled when it is empty or being
  // accepted, so a stalled beat holds. The head entry leaves the FIFO only when its
  // phase-1 beat is accepted. x/y hold the last accepted beat's coordinates
  // whenever the register is empty.
  always_comb begin
    hs       = valid_q & bus.pix_ready;
    pop      = hs & phase_q;
    ld       = 1'b0;
    ld_phase = 1'b0;
    ld_entry = head;
    if (!valid_q) begin
      ld = (count != '0);
    end else if (hs) begin
      if (!phase_q) begin
        ld       = 1'b1;
        ld_phase = 1'b1;
      end else if (nxt_avail) begin
        ld       = 1'b1;
        ld_entry = nxt;
      end
    end
    ld_data = ld_phase ? ld_entry.word[31:16] : ld_entry.word[15:0];
    ld_sof  = ~ld_phase & ld_entry.sof;
    ld_sol  = ~ld_phase & ld_entry.sol;
    ld_eol  = ld_phase & ld_entry.eol;
    ld_x    = ld_sol ? '0 : x_q + XW'(2);
    ld_y    = ld_sof ? '0 : (ld_sol ? y_q + YW'(1) : y_q);
  end

  // Output register: load a new beat, or go idle after a handshake with nothing behind it.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      phase_q <= 1'b0;
      sof_q   <= 1'b0;
      sol_q   <= 1'b0;
      eol_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else if (ld) begin
      data_q  <= ld_data;
      valid_q <= 1'b1;
      phase_q <= ld_phase;
      sof_q   <= ld_sof;
      sol_q   <= ld_sol;
      eol_q   <= ld_eol;
      x_q     <= ld_x;
      y_q     <= ld_y;
    end else if (hs) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.pix_data  = data_q;
  assign bus.pix_valid = valid_q;
  assign bus.pix_sof   = sof_q;
  assign bus.pix_sol   = sol_q;
  assign bus.pix_eol   = eol_q;
  assign bus.pix_x     = x_q;
  assign bus.pix_y     = y_q;
  assign bus.overflow  = overflow_q;
endmodule
